// File: rtl/dataflow_seq_pkg.sv
// Shared types and widths for the dataflow_seq sequencer and its arbiter.
package dataflow_seq_pkg;

  localparam int DP_IN_W  = 4;
  localparam int DP_OUT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/dataflow_seq_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from i_ptr and wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_k = IDX_W'((32'(i_ptr) + off) % NREQ);
      if (!o_valid && i_req[w_k]) begin
        o_valid      = 1'b1;
        o_idx        = w_k;
        o_grant[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dataflow_seq.sv
// Round-robin sequencer sharing one combinational gate datapath between NREQ requesters.
// Define DATAFLOW_SEQ_STABLE_CHECK_EN to add a post-capture stability check driving rsp_err.
module dataflow_seq
  import dataflow_seq_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int SETTLE = 3,
  parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [DP_IN_W*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DP_IN_W-1:0]       dp_i,
  input  logic [DP_OUT_W-1:0]      dp_o,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DP_OUT_W-1:0]      rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int CNT_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_rsp_id;
  logic [DP_IN_W-1:0]   r_dp_i;
  logic [DP_OUT_W-1:0]  r_rsp_data;
  logic                 r_rsp_valid;
  logic                 r_busy;

  logic [NREQ-1:0]      w_grant;
  logic [ID_W-1:0]      w_idx;
  logic                 w_any;
  logic [DP_IN_W-1:0]   w_data;
  logic [ID_W-1:0]      w_ptr_next;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_idx == ID_W'(k)) w_data = req_data[DP_IN_W*k +: DP_IN_W];
    end
  end

  assign w_ptr_next = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign req_ready  = (r_state == ST_IDLE && !rst) ? w_grant : '0;

`ifdef DATAFLOW_SEQ_STABLE_CHECK_EN
  logic r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_rsp_id    <= '0;
      r_dp_i      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef DATAFLOW_SEQ_STABLE_CHECK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_dp_i   <= w_data;
            r_rsp_id <= w_idx;
            r_rr_ptr <= w_ptr_next;
            r_cnt    <= CNT_W'(SETTLE - 1);
            r_busy   <= 1'b1;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_data <= dp_o;
`ifdef DATAFLOW_SEQ_STABLE_CHECK_EN
            r_state    <= ST_CHECK;
`else
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef DATAFLOW_SEQ_STABLE_CHECK_EN
        // Second sample one cycle after capture; rsp_data keeps the first.
        ST_CHECK: begin
          r_rsp_err   <= (dp_o != r_rsp_data);
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    a_settle_legal: assert (SETTLE >= 1) else $error("dataflow_seq: SETTLE must be >= 1");
  end

  assign dp_i      = r_dp_i;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: doc/dataflow_seq.md
Name: dataflow_seq

Overview:
- Sequencer and arbiter that shares one 4-input/5-output combinational gate datapath between NREQ requesters.
- Accepts one operand at a time using round-robin grant, and drives it onto the datapath.
- Waits SETTLE cycles to cover gate propagation delays, then captures the datapath outputs.
- Returns the captured result with the requester ID over a valid/ready response channel.

Parameters:
- NREQ, 2, number of requesters (2..8)
- SETTLE, 3, cycles dp_i is held before capture (>=1; 0 is illegal, flagged by a simulation assertion)
- ID_W, 1, width of rsp_id; equals $clog2(NREQ), minimum 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  4*NREQ  operands; requester k uses bits [4k+3:4k]
- req_ready  out  NREQ  one-hot grant; combinational, only in IDLE
- dp_i  out  4  datapath inputs {i3,i2,i1,i0}, registered
- dp_o  in  5  datapath outputs {o0,o1,o2[1],o2[0],o3}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  5  captured dp_o
- rsp_err  out  1  stability error (see Optional Feature)
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - dp_i, rsp_valid, rsp_id, rsp_data, rsp_err, busy and the round-robin pointer rr_ptr are all set to 0.
  - req_ready is 0 while rst is high.
- States are IDLE, SETTLE, (CHECK), RESP.
- IDLE:
  - The grant g is the first k with req_valid[k]=1, searching from rr_ptr upward and wrapping at NREQ.
  - req_ready = onehot(g). If no request is valid, req_ready=0.
  - On accept at cycle T: dp_i <= req_data[g], rsp_id <= g, rr_ptr <= (g+1) mod NREQ, settle counter <= SETTLE-1, state <= SETTLE.
- SETTLE:
  - dp_i is held. The counter decrements each cycle.
  - When the counter is 0: rsp_data <= dp_o. Without the feature, state <= RESP.
  - The capture edge is the end of cycle T+SETTLE.
- RESP:
  - rsp_valid=1 from cycle T+SETTLE+1; with the feature enabled, from T+SETTLE+2.
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake: rsp_valid <= 0, state <= IDLE.
  - The earliest next accept is the cycle after the handshake.
- dp_i keeps its last operand while in IDLE and never changes outside an accept.
- Only one operation is in flight. Requests arriving while busy wait; req_valid must stay high until accepted.
- A requester that drops req_valid before it is granted is simply skipped.
- Simultaneous requests: exactly one grant per accept, in rotating order. No requester starves. Worst-case wait is NREQ-1 operations.
- rsp_ready held high: one operation completes every SETTLE+2 cycles (SETTLE+3 with the feature).
- Reset mid-operation: the operation is abandoned with no response. rr_ptr returns to 0.

Optional Feature:
- Macro: DATAFLOW_SEQ_STABLE_CHECK_EN.
- Defined:
  - After the SETTLE capture, the FSM enters CHECK for one cycle and samples dp_o again.
  - rsp_err <= (second sample != rsp_data).
  - rsp_data keeps the first sample. Then state <= RESP.
- Undefined: the CHECK state does not exist and rsp_err is tied to 0.

Decomposition:
- Package dataflow_seq_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, RESP);
  - DP_IN_W=4 and DP_OUT_W=5.
- One sub-module, rr_arbiter:
  - parameter NREQ;
  - inputs req and ptr, output onehot grant plus binary index;
  - purely combinational.
- The FSM, counter and registers stay in dataflow_seq.

Test Plan:
The bench models the datapath as dp_o = {i2|i3, i2&i3, i0&i1, i0|i1, (i0^i1)&(i2|i3)}, applied with a delay of SETTLE-1 cycles.
- Single request: req 0, data 4'b0011 at T, rsp_ready=1 → rsp_valid at T+4, rsp_id=0, rsp_data=5'b00110, rsp_err=0, busy low at T+5.
- Contention: both requesters valid continuously; req0=4'b1101, req1=4'b0011 → responses alternate id 0 (5'b11011), 1 (5'b00110), 0, 1.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid → outputs held stable, no new req_ready pulse, completion on the first ready cycle.
- Reset mid-op: rst asserted in SETTLE → next cycle all outputs 0, no response emitted, first later request is serviced from requester 0 priority.
- Feature on: the datapath model changes dp_o in the cycle after capture → rsp_err=1, rsp_data equals the first sample, rsp_valid at T+5.
- Skip: requester 1 drops req_valid before grant while requester 0 is pending → only requester 0 is granted, rr_ptr=1 afterwards.
